// File: rtl/sm_pkg.sv
// Shared constants, state encoding and helpers for the sign-magnitude accumulator.
package sm_pkg;

  localparam int DATA_W_DEF  = 18;
  localparam int GUARD_W_DEF = 6;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Callers widen their magnitude to 64 bits so one helper serves every width.
  function automatic logic sm_is_zero(input logic [63:0] mag);
    return (mag == 64'd0);
  endfunction

endpackage

// File: rtl/sm_add_core.sv
// Combinational sign-magnitude adder: larger magnitude sets the sign, zero is always +0.
module sm_add_core
  import sm_pkg::*;
#(
  parameter int MAG_W = 23
) (
  input  logic             a_sign,
  input  logic [MAG_W-1:0] a_mag,
  input  logic             b_sign,
  input  logic [MAG_W-1:0] b_mag,
  output logic             sum_sign,
  output logic [MAG_W-1:0] sum_mag,
  output logic             carry
);

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    sum_sign = a_sign;
    sum_mag  = '0;
    carry    = 1'b0;
    if (a_sign == b_sign) begin
      {carry, sum_mag} = {1'b0, a_mag} + {1'b0, b_mag};
    end else if (a_mag >= b_mag) begin
      sum_mag = a_mag - b_mag;
    end else begin
      sum_sign = b_sign;
      sum_mag  = b_mag - a_mag;
    end
    if (sm_is_zero(64'(sum_mag))) sum_sign = 1'b0;
  end

endmodule

// File: rtl/sm_accumulator.sv
// Streams sign-magnitude terms into a guard-bit accumulator and emits one saturated sum per packet.
module sm_accumulator
  import sm_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int GUARD_W = GUARD_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  output logic [CNT_W-1:0]  out_count
);

  localparam int OUT_MAG_W = DATA_W - 1;
  localparam int INT_MAG_W = OUT_MAG_W + GUARD_W;
  localparam logic [CNT_W-1:0]     CNT_MAX     = '1;
  localparam logic [INT_MAG_W-1:0] OUT_MAG_MAX = {{GUARD_W{1'b0}}, {OUT_MAG_W{1'b1}}};

  state_e                 state_q, state_d;
  logic                   acc_sign_q, acc_sign_d;
  logic [INT_MAG_W-1:0]   acc_mag_q, acc_mag_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   sticky_q, sticky_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_W-1:0]      out_data_q, out_data_d;
  logic                   out_sat_q, out_sat_d;
  logic [CNT_W-1:0]       out_count_q, out_count_d;

  logic                   term_sign;
  logic [INT_MAG_W-1:0]   term_mag;
  logic                   accept;
  logic                   sum_sign;
  logic [INT_MAG_W-1:0]   sum_mag;
  logic                   sum_carry;
  logic                   fin_over;

  assign term_sign = in_data[DATA_W-1];
  assign term_mag  = {{GUARD_W{1'b0}}, in_data[DATA_W-2:0]};
  assign accept    = in_valid && in_ready_q;

  sm_add_core #(.MAG_W(INT_MAG_W)) u_add_core (
    .a_sign   (acc_sign_q),
    .a_mag    (acc_mag_q),
    .b_sign   (term_sign),
    .b_mag    (term_mag),
    .sum_sign (sum_sign),
    .sum_mag  (sum_mag),
    .carry    (sum_carry)
  );

  always_comb begin
    state_d     = state_q;
    acc_sign_d  = acc_sign_q;
    acc_mag_d   = acc_mag_q;
    count_d     = count_q;
    sticky_d    = sticky_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_count_d = out_count_q;
    fin_over    = 1'b0;

    case (state_q)
      IDLE: if (accept) begin
        acc_sign_d = term_sign && !sm_is_zero(64'(term_mag));
        acc_mag_d  = term_mag;
        count_d    = CNT_W'(1);
        sticky_d   = 1'b0;
        state_d    = in_last ? HOLD : ACC;
      end
      ACC: if (accept) begin
        // An overflowing magnitude clamps and leaves a sticky mark on the result.
        acc_sign_d = sum_sign;
        acc_mag_d  = sum_carry ? '1 : sum_mag;
        sticky_d   = sticky_q | sum_carry;
        count_d    = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
        if (in_last) state_d = HOLD;
      end
      HOLD: if (out_ready) begin
        state_d    = IDLE;
        acc_sign_d = 1'b0;
        acc_mag_d  = '0;
        count_d    = '0;
        sticky_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Result registers load only on the beat that closes a packet, so they hold through backpressure.
    if (state_q != HOLD && state_d == HOLD) begin
      fin_over    = acc_mag_d > OUT_MAG_MAX;
      out_data_d  = fin_over ? {acc_sign_d, {OUT_MAG_W{1'b1}}}
                             : {acc_sign_d, acc_mag_d[OUT_MAG_W-1:0]};
      out_sat_d   = fin_over | sticky_d;
      out_count_d = count_d;
    end

    in_ready_d  = (state_d != HOLD);
    out_valid_d = (state_d == HOLD);

    if (clear) begin
      state_d     = IDLE;
      acc_sign_d  = 1'b0;
      acc_mag_d   = '0;
      count_d     = '0;
      sticky_d    = 1'b0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_sat_d   = 1'b0;
      out_count_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_sign_q  <= 1'b0;
      acc_mag_q   <= '0;
      count_q     <= '0;
      sticky_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_sign_q  <= acc_sign_d;
      acc_mag_q   <= acc_mag_d;
      count_q     <= count_d;
      sticky_q    <= sticky_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_sm_accumulator.sv
// Directed bench for sm_accumulator: inputs change and outputs are sampled on the falling edge.
module tb_sm_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [17:0] out_data;
  logic        out_sat;
  logic [7:0]  out_count;

  int tests = 0;
  int fails = 0;

  sm_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  // Presents one beat at a falling edge and returns on the falling edge after it is taken.
  task automatic send(input logic [17:0] d, input logic last, input logic clr);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = last; clear = clr;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
  endtask

  // Waits for a result, captures it and completes the handshake.
  task automatic pop(output logic [17:0] d, output logic s, output logic [7:0] c);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      tests++; fails++;
      $display("FAIL pop_timeout: out_valid stayed %b, required 1", out_valid);
    end
    d = out_data; s = out_sat; c = out_count;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    tests++; if (out_data !== 18'h0) begin fails++; $display("FAIL reset_out_data: got %h required 00000", out_data); end
    tests++; if ({out_sat, out_count} !== 9'h0) begin fails++; $display("FAIL reset_sat_count: got %b/%0d required 0/0", out_sat, out_count); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_sign_resolution();
    logic [17:0] d; logic s; logic [7:0] c;
    send(18'h00003, 1'b0, 1'b0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sign_mid_valid: got %b required 0", out_valid); end
    send(18'h20005, 1'b1, 1'b0);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL sign_latency: out_valid got %b required 1", out_valid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL sign_hold_ready: got %b required 0", in_ready); end
    pop(d, s, c);
    tests++; if (d !== 18'h20002) begin fails++; $display("FAIL sign_data: got %h required 20002", d); end
    tests++; if (s !== 1'b0) begin fails++; $display("FAIL sign_sat: got %b required 0", s); end
    tests++; if (c !== 8'd2) begin fails++; $display("FAIL sign_count: got %0d required 2", c); end
  endtask

  task automatic test_cancellation();
    logic [17:0] d; logic s; logic [7:0] c;
    send(18'h00005, 1'b0, 1'b0);
    send(18'h20005, 1'b1, 1'b0);
    pop(d, s, c);
    tests++; if (d !== 18'h00000) begin fails++; $display("FAIL cancel_data: got %h required 00000", d); end
    tests++; if (c !== 8'd2) begin fails++; $display("FAIL cancel_count: got %0d required 2", c); end
    send(18'h20000, 1'b1, 1'b0);
    pop(d, s, c);
    tests++; if (d !== 18'h00000) begin fails++; $display("FAIL negzero_data: got %h required 00000", d); end
    tests++; if ({s, c} !== 9'd1) begin fails++; $display("FAIL negzero_sat_count: got %b/%0d required 0/1", s, c); end
  endtask

  task automatic test_guard_bits();
    logic [17:0] d; logic s; logic [7:0] c;
    send(18'h1FFFF, 1'b0, 1'b0);
    send(18'h1FFFF, 1'b0, 1'b0);
    send(18'h3FFFF, 1'b1, 1'b0);
    pop(d, s, c);
    tests++; if (d !== 18'h1FFFF) begin fails++; $display("FAIL guard_data: got %h required 1ffff", d); end
    tests++; if ({s, c} !== {1'b0, 8'd3}) begin fails++; $display("FAIL guard_sat_count: got %b/%0d required 0/3", s, c); end
    send(18'h1FFFF, 1'b0, 1'b0);
    send(18'h1FFFF, 1'b1, 1'b0);
    pop(d, s, c);
    tests++; if (d !== 18'h1FFFF) begin fails++; $display("FAIL outsat_data: got %h required 1ffff", d); end
    tests++; if (s !== 1'b1) begin fails++; $display("FAIL outsat_flag: got %b required 1", s); end
  endtask

  // 65 full-scale terms overflow the 23-bit magnitude; 64 negatives then bring it back to 63.
  task automatic test_sticky_clamp();
    logic [17:0] d; logic s; logic [7:0] c;
    for (int i = 0; i < 65; i++) send(18'h1FFFF, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) send(18'h3FFFF, i == 63, 1'b0);
    pop(d, s, c);
    tests++; if (d !== 18'h0003F) begin fails++; $display("FAIL clamp_data: got %h required 0003f", d); end
    tests++; if (s !== 1'b1) begin fails++; $display("FAIL clamp_sticky: got %b required 1", s); end
    tests++; if (c !== 8'd129) begin fails++; $display("FAIL clamp_count: got %0d required 129", c); end
  endtask

  task automatic test_backpressure();
    logic [17:0] d; logic s; logic [7:0] c;
    send(18'h00009, 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 18'h00004; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d]: got %b required 0", i, in_ready); end
      tests++; if ({out_valid, out_data, out_sat, out_count} !== {1'b1, 18'h00009, 1'b0, 8'd1})
        begin fails++; $display("FAIL bp_stable[%0d]: got %b/%h/%b/%0d required 1/00009/0/1", i, out_valid, out_data, out_sat, out_count); end
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++; if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL bp_release: valid/ready got %b%b required 01", out_valid, in_ready); end
    send(18'h00002, 1'b1, 1'b0);
    pop(d, s, c);
    tests++; if ({d, c} !== {18'h00002, 8'd1}) begin fails++; $display("FAIL bp_fresh: got %h/%0d required 00002/1", d, c); end
  endtask

  task automatic test_clear();
    logic [17:0] d; logic s; logic [7:0] c;
    send(18'h00005, 1'b0, 1'b0);
    send(18'h00006, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clear_no_valid[%0d]: got %b required 0", i, out_valid); end
      @(negedge clk);
    end
    send(18'h20001, 1'b0, 1'b0);
    send(18'h20002, 1'b1, 1'b0);
    pop(d, s, c);
    tests++; if ({d, s, c} !== {18'h20003, 1'b0, 8'd2}) begin fails++; $display("FAIL clear_next: got %h/%b/%0d required 20003/0/2", d, s, c); end
    send(18'h00007, 1'b1, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    tests++; if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL clear_held: valid/ready got %b%b required 01", out_valid, in_ready); end
  endtask

  task automatic test_async_reset();
    logic [17:0] d; logic s; logic [7:0] c;
    send(18'h00011, 1'b1, 1'b0);
    pop(d, s, c);
    send(18'h00004, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({in_ready, out_valid, out_sat} !== 3'b000) begin fails++; $display("FAIL async_flags: ready/valid/sat got %b%b%b required 000", in_ready, out_valid, out_sat); end
    tests++; if ({out_data, out_count} !== 26'h0) begin fails++; $display("FAIL async_data: got %h/%0d required 00000/0", out_data, out_count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(18'h00001, 1'b1, 1'b0);
    pop(d, s, c);
    tests++; if ({d, c} !== {18'h00001, 8'd1}) begin fails++; $display("FAIL async_fresh: got %h/%0d required 00001/1", d, c); end
  endtask

  task automatic test_long_packet();
    logic [17:0] d; logic s; logic [7:0] c;
    for (int i = 0; i < 300; i++) send(18'h00001, i == 299, 1'b0);
    pop(d, s, c);
    tests++; if (d !== 18'h0012C) begin fails++; $display("FAIL long_data: got %h required 0012c", d); end
    tests++; if (c !== 8'd255) begin fails++; $display("FAIL long_count: got %0d required 255", c); end
    tests++; if (s !== 1'b0) begin fails++; $display("FAIL long_sat: got %b required 0", s); end
  endtask

  initial begin
    test_reset();
    test_sign_resolution();
    test_cancellation();
    test_guard_bits();
    test_sticky_clamp();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_long_packet();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sm_accumulator.md
Name: sm_accumulator

Overview:
- Parametrised, sequential successor to the team's 18-bit sign-magnitude adder.
- Accepts a stream of sign-magnitude terms with valid/ready and last, and accumulates them internally using guard bits.
- On the last term it emits one saturated sign-magnitude sum with valid/ready backpressure.
- Used after the conv/FC multipliers in the LeNet datapath to sum a kernel window or neuron's products.

Parameters:
- DATA_W, 18: total width of input/output words; bit DATA_W-1 is sign, bits DATA_W-2:0 are magnitude.
- GUARD_W, 6: extra internal magnitude bits; guarantees exact sums of up to 2^GUARD_W full-scale terms.
- CNT_W, 8: width of the term counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort; discards the partial sum and any held result, returns to IDLE.
- in_valid  in  1  input term valid.
- in_ready  out  1  block can accept a term.
- in_data  in  DATA_W  sign-magnitude term.
- in_last  in  1  final term of the current sum; sampled with in_valid&&in_ready.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_W  saturated sign-magnitude sum.
- out_sat  out  1  result was clipped, or internal magnitude saturated during accumulation.
- out_count  out  CNT_W  number of terms summed; saturates at 2^CNT_W-1.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: in_ready=0 during reset, then 1; out_valid=0, out_data=0, out_sat=0, out_count=0; internal accumulator +0, sticky flag 0, state IDLE.
- Internal accumulator: sign bit plus magnitude of (DATA_W-1+GUARD_W) bits.
- States:
  - IDLE: in_ready=1. An accepted beat loads acc=term, count=1. Go to ACC, or to HOLD if in_last.
  - ACC: in_ready=1. An accepted beat sets acc=acc+term and count+1. Go to HOLD if in_last.
  - HOLD: in_ready=0, out_valid=1. On out_ready, go to IDLE and clear acc, count and sticky flag.
- Latency: out_valid rises on the cycle after the in_last beat is accepted. Throughput is 1 term/cycle. One idle bubble follows each result (no accept in HOLD).
- Add rule, same signs: sign is kept and magnitudes are added.
- Add rule, different signs: the larger magnitude's sign wins and the result magnitude is the difference.
- Equal magnitudes with opposite signs give +0. Every zero result, including a loaded -0 input, is normalised to sign 0.
- Internal overflow: if the magnitude sum exceeds the internal width, the magnitude clamps to all-ones and the sticky flag is set. The clamp persists for later terms.
- Output saturation: if the final magnitude exceeds 2^(DATA_W-1)-1, out_data = {sign, all-ones} and out_sat=1.
- out_sat is the OR of the output-saturation condition and the sticky flag.
- Output stability: out_data, out_sat and out_count are registered and stay stable while out_valid=1 and out_ready=0.
- out_count saturates and does not wrap.
- clear has priority over every other event in the same cycle. A beat presented with clear is dropped and a held result is discarded.
- in_valid with in_ready=0 is ignored. No data is dropped silently, because the producer must hold the beat.
- If rst_n asserts mid-sum or mid-HOLD, all state returns to reset values immediately.

Decomposition:
- Package sm_pkg:
  - default DATA_W and GUARD_W constants;
  - state encoding localparams: IDLE=0, ACC=1, HOLD=2;
  - helper function sm_is_zero.
- Sub-module sm_add_core (combinational, parametrised by width):
  - inputs are two sign-magnitude operands of MAG_W bits;
  - outputs are the sum with zero normalisation and a carry-out used for the clamp.
  - Instantiated once at internal width.

Test Plan:
- Sign resolution: beats +3 (0x00003), then -5 last (0x20005) -> out_data=0x20002, out_sat=0, out_count=2, out_valid one cycle after the last accept.
- Cancellation and negative-zero: +5 then -5 last -> out_data=0x00000, sign 0. Single beat 0x20000 with last -> out_data=0x00000, count=1.
- Guard bits: 0x1FFFF, 0x1FFFF, then 0x3FFFF last -> out_data=0x1FFFF, out_sat=0. Two beats of 0x1FFFF -> out_data=0x1FFFF, out_sat=1.
- Backpressure: hold out_ready=0 for 3 cycles after a result -> in_ready=0 and out_* stable. On out_ready=1, in_ready returns to 1 the next cycle and a new sum starts from +0.
- Abort and reset: assert clear on the 2nd of 4 beats -> no out_valid, and the next packet -1, -2 last gives 0x20003. Drop rst_n mid-sum -> outputs go to reset values asynchronously.
- Long packet: 300 beats of +1 -> out_data=0x0012C, out_count=255 (saturated), out_sat=0.
